// File: rtl/multicycle_cpu_if.sv
// Instruction-memory fetch bus: the core issues req/addr, the memory answers
// with ready/instr in the same or any later cycle.
interface multicycle_cpu_if #(
   parameter int PC_W = 32
);
   logic            imem_req_o;
   logic [PC_W-1:0] imem_addr_o;
   logic            imem_ready_i;
   logic [31:0]     imem_instr_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ready_i,
      input  imem_instr_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ready_i,
      output imem_instr_i
   );
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/WB sequencing over an
// external stallable instruction fetch, with an internal register file,
// a debug read port and a retire counter.
module multicycle_cpu #(
   parameter int              DATA_W   = 32,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   multicycle_cpu_if.master  imem,
   output logic              retire_o,
   output logic [31:0]       retire_cnt_o,
   output logic              halted_o,
   output logic [PC_W-1:0]   pc_o,
   input  logic [4:0]        dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   // Low 28 PC bits replaced by a jump; narrower PCs keep only what fits.
   localparam logic [PC_W-1:0] JMASK = PC_W'(28'hFFF_FFFF);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q;
   logic [31:0]         ir_q;
   logic [DATA_W-1:0]   a_q, b_q, imm_q, alu_q;
   logic                taken_q;
   logic [31:0]         cnt_q;
   logic [DATA_W-1:0]   regs [32];

   logic [5:0]          op, funct;
   logic [4:0]          rs, rt, rd, wr_addr;
   logic                legal, wr_en;
   logic [DATA_W-1:0]   alu_res;
   logic [PC_W-1:0]     pc4, br_target, j_target, pc_next;

   assign op    = ir_q[31:26];
   assign funct = ir_q[5:0];
   assign rs    = ir_q[25:21];
   assign rt    = ir_q[20:16];
   assign rd    = ir_q[15:11];

   // Decode: legality and destination register of the instruction in IR.
   always_comb begin
      legal   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = rd;
      case (op)
         OP_RTYPE: begin
            wr_en = 1'b1;
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
               default:                               legal = 1'b0;
            endcase
         end
         OP_ADDI, OP_SLTI: begin
            legal   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = rt;
         end
         OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   // ALU on the operands latched in DECODE.
   always_comb begin
      alu_res = '0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_res = a_q + b_q;
               FN_SUB:  alu_res = a_q - b_q;
               FN_AND:  alu_res = a_q & b_q;
               FN_OR:   alu_res = a_q | b_q;
               FN_SLT:  alu_res = DATA_W'($signed(a_q) < $signed(b_q));
               default: alu_res = '0;
            endcase
         end
         OP_ADDI: alu_res = a_q + imm_q;
         OP_SLTI: alu_res = DATA_W'($signed(a_q) < $signed(imm_q));
         default: alu_res = '0;
      endcase
   end

   // Next-PC selection applied at the end of WB.
   always_comb begin
      pc4       = pc_q + PC_W'(4);
      br_target = pc4 + (PC_W'($signed(imm_q)) << 2);
      j_target  = (pc4 & ~JMASK) | PC_W'({ir_q[25:0], 2'b00});
      pc_next   = pc4;
      case (op)
         OP_J:           pc_next = j_target;
         OP_BEQ, OP_BNE: pc_next = taken_q ? br_target : pc4;
         default:        pc_next = pc4;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Controller next state and fetch/retire strobes.
   always_comb begin
      state_d         = state_q;
      imem.imem_req_o = 1'b0;
      retire_o        = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem.imem_req_o = 1'b1;
            if (imem.imem_ready_i) state_d = S_DECODE;
         end
         S_DECODE: state_d = legal ? S_EXEC : S_HALT;
         S_EXEC:   state_d = S_WB;
         S_WB: begin
            retire_o = 1'b1;
            state_d  = S_FETCH;
         end
         default:  state_d = S_HALT;
      endcase
   end

   // Datapath registers, register file, PC and retire counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         taken_q <= 1'b0;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         case (state_q)
            S_FETCH: if (imem.imem_ready_i) ir_q <= imem.imem_instr_i;
            S_DECODE: begin
               a_q   <= regs[rs];
               b_q   <= regs[rt];
               imm_q <= DATA_W'($signed(ir_q[15:0]));
            end
            S_EXEC: begin
               alu_q   <= alu_res;
               taken_q <= (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
            end
            S_WB: begin
               if (wr_en && (wr_addr != 5'd0)) regs[wr_addr] <= alu_q;
               pc_q  <= pc_next;
               cnt_q <= cnt_q + 32'd1;
            end
            default: ;
         endcase
      end
   end

   assign imem.imem_addr_o = pc_q;
   assign pc_o             = pc_q;
   assign retire_cnt_o     = cnt_q;
   assign halted_o         = (state_q == S_HALT);
   assign dbg_data_o       = regs[dbg_addr_i];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed vector table, hand sequences for reset,
// halt and stall corners, randomized programs against an ISA-level model,
// and a narrow-width instance for wrap/truncation behaviour.
module tb_multicycle_cpu;

   logic        clk = 1'b0;
   logic        rst32, rst8, ready, sel;
   logic [4:0]  dbg_addr;
   logic [31:0] mem [256];

   always #5 clk = ~clk;

   multicycle_cpu_if #(.PC_W(32)) bus32 ();
   multicycle_cpu_if #(.PC_W(8))  bus8 ();

   assign bus32.imem_ready_i = ready;
   assign bus8.imem_ready_i  = ready;
   assign bus32.imem_instr_i = mem[bus32.imem_addr_o[9:2]];
   assign bus8.imem_instr_i  = mem[{2'b00, bus8.imem_addr_o[7:2]}];

   logic        ret32, halt32, ret8, halt8;
   logic [31:0] cnt32, cnt8, pc32, dbg32;
   logic [7:0]  pc8;
   logic [15:0] dbg8;

   multicycle_cpu #(.DATA_W(32), .PC_W(32), .RESET_PC(32'h100)) dut32 (
      .clk_i(clk), .rst_i(rst32), .imem(bus32.master),
      .retire_o(ret32), .retire_cnt_o(cnt32), .halted_o(halt32),
      .pc_o(pc32), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg32));

   multicycle_cpu #(.DATA_W(16), .PC_W(8), .RESET_PC(8'hFC)) dut8 (
      .clk_i(clk), .rst_i(rst8), .imem(bus8.master),
      .retire_o(ret8), .retire_cnt_o(cnt8), .halted_o(halt8),
      .pc_o(pc8), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg8));

   logic        c_req, c_ret, c_halt;
   logic [31:0] c_addr, c_pc, c_cnt, c_dbg;

   // Observe whichever instance is currently under test.
   always_comb begin
      if (sel) begin
         c_req = bus8.imem_req_o;  c_addr = {24'd0, bus8.imem_addr_o};
         c_ret = ret8;  c_halt = halt8;  c_cnt = cnt8;
         c_pc  = {24'd0, pc8};  c_dbg = {16'd0, dbg8};
      end else begin
         c_req = bus32.imem_req_o; c_addr = bus32.imem_addr_o;
         c_ret = ret32; c_halt = halt32; c_cnt = cnt32;
         c_pc  = pc32;  c_dbg = dbg32;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] t);
      return {6'h02, t};
   endfunction

   // ISA-level reference state.
   logic [31:0] m_regs [32];
   logic [31:0] m_pc, m_cnt;

   task automatic model_reset(input logic [31:0] rpc);
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc  = rpc;
      m_cnt = '0;
   endtask

   task automatic model_step(input logic [31:0] ins, output bit legal, output logic [4:0] dest);
      logic [31:0] a, b, simm, pc4, npc, res;
      bit wr;
      a    = m_regs[ins[25:21]];
      b    = m_regs[ins[20:16]];
      simm = {{16{ins[15]}}, ins[15:0]};
      pc4  = m_pc + 32'd4;
      npc  = pc4;
      res  = '0;
      wr   = 1'b0;
      dest = 5'd0;
      legal = 1'b1;
      case (ins[31:26])
         6'h00: begin
            wr = 1'b1; dest = ins[15:11];
            case (ins[5:0])
               6'h20: res = a + b;
               6'h22: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: legal = 1'b0;
            endcase
         end
         6'h08: begin wr = 1'b1; dest = ins[20:16]; res = a + simm; end
         6'h0A: begin wr = 1'b1; dest = ins[20:16];
                      res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; end
         6'h04: npc = (a == b) ? pc4 + (simm << 2) : pc4;
         6'h05: npc = (a != b) ? pc4 + (simm << 2) : pc4;
         6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
         default: legal = 1'b0;
      endcase
      if (legal) begin
         if (wr && dest != 5'd0) m_regs[dest] = res;
         m_pc  = npc;
         m_cnt = m_cnt + 32'd1;
      end
   endtask

   function automatic logic [31:0] rand_instr();
      int k;
      logic [5:0] fns [5];
      fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
      k = $urandom_range(0, 9);
      if (k <= 4) return enc_r(5'($urandom), 5'($urandom), 5'($urandom), fns[k]);
      if (k == 5) return enc_i(6'h08, 5'($urandom), 5'($urandom), 16'($urandom));
      if (k == 6) return enc_i(6'h0A, 5'($urandom), 5'($urandom), 16'($urandom));
      if (k == 7) return enc_i(6'h04, 5'($urandom), 5'($urandom), 16'($urandom_range(0, 16) - 8));
      if (k == 8) return enc_i(6'h05, 5'($urandom), 5'($urandom), 16'($urandom_range(0, 16) - 8));
      return enc_j(26'($urandom_range(0, 255)));
   endfunction

   // One instruction from FETCH entry: stall cycles, then 4-cycle sequence.
   task automatic run_instr(input logic [31:0] faddr, input int stall, input bit legal,
                            input logic [4:0] dreg, input logic [31:0] dval,
                            input logic [31:0] npc, input logic [31:0] ncnt, input string tag);
      ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
         chk(32'(c_req), 32'd1, {tag, " stall req"});
         chk(c_addr, faddr, {tag, " stall addr"});
         chk(32'(c_ret), 32'd0, {tag, " stall retire"});
         @(posedge clk); #1;
      end
      ready = 1'b1;
      chk(32'(c_req), 32'd1, {tag, " fetch req"});
      chk(c_addr, faddr, {tag, " fetch addr"});
      @(posedge clk); #1;
      ready = 1'b0;
      chk(32'(c_req), 32'd0, {tag, " decode req"});
      @(posedge clk); #1;
      if (!legal) begin
         chk(32'(c_halt), 32'd1, {tag, " halted"});
         chk(32'(c_req), 32'd0, {tag, " halt req"});
         chk(c_cnt, ncnt, {tag, " halt cnt"});
         return;
      end
      chk(32'(c_halt), 32'd0, {tag, " not halted"});
      chk(32'(c_ret), 32'd0, {tag, " exec retire"});
      @(posedge clk); #1;
      chk(32'(c_ret), 32'd1, {tag, " wb retire"});
      @(posedge clk); #1;
      chk(32'(c_ret), 32'd0, {tag, " post retire"});
      chk(c_pc, npc, {tag, " pc"});
      chk(c_cnt, ncnt, {tag, " cnt"});
      dbg_addr = dreg;
      #1;
      chk(c_dbg, dval, {tag, " dbg"});
   endtask

   task automatic do_reset(input bit s, input logic [31:0] rpc);
      sel   = s;
      ready = 1'b1;
      if (s) rst8 = 1'b1; else rst32 = 1'b1;
      #1;
      chk(c_pc, rpc, "rst pc async");
      @(posedge clk); #1;
      chk(32'(c_req), 32'd1, "rst req");
      chk(c_addr, rpc, "rst addr");
      chk(32'(c_ret), 32'd0, "rst retire");
      chk(c_cnt, 32'd0, "rst cnt");
      chk(32'(c_halt), 32'd0, "rst halted");
      @(posedge clk); #1;
      chk(c_addr, rpc, "rst addr held");
      if (s) rst8 = 1'b0; else rst32 = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      int          stall;
      bit          legal;
      logic [4:0]  dreg;
      logic [31:0] dval;
      logic [31:0] npc;
      logic [31:0] ncnt;
   } vec_t;

   vec_t tbl [16];

   initial begin
      rst32 = 1'b0; rst8 = 1'b0; ready = 1'b0; sel = 1'b0; dbg_addr = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      tbl[0]  = '{32'h100, enc_i(6'h08, 0, 1, 16'hFFFB), 0, 1, 1, 32'hFFFF_FFFB, 32'h104, 1};
      tbl[1]  = '{32'h104, enc_i(6'h08, 0, 2, 16'h0003), 0, 1, 2, 32'h3,         32'h108, 2};
      tbl[2]  = '{32'h108, enc_r(1, 2, 3, 6'h2A),        2, 1, 3, 32'h1,         32'h10C, 3};
      tbl[3]  = '{32'h10C, enc_r(2, 1, 4, 6'h22),        7, 1, 4, 32'h8,         32'h110, 4};
      tbl[4]  = '{32'h110, enc_i(6'h0A, 1, 5, 16'hFFFC), 0, 1, 5, 32'h1,         32'h114, 5};
      tbl[5]  = '{32'h114, enc_r(1, 2, 6, 6'h24),        0, 1, 6, 32'h3,         32'h118, 6};
      tbl[6]  = '{32'h118, enc_r(1, 2, 7, 6'h25),        0, 1, 7, 32'hFFFF_FFFB, 32'h11C, 7};
      tbl[7]  = '{32'h11C, enc_r(1, 1, 8, 6'h20),        1, 1, 8, 32'hFFFF_FFF6, 32'h120, 8};
      tbl[8]  = '{32'h120, enc_i(6'h08, 0, 0, 16'h0009), 0, 1, 0, 32'h0,         32'h124, 9};
      tbl[9]  = '{32'h124, enc_j(26'h10),                0, 1, 1, 32'hFFFF_FFFB, 32'h040, 10};
      tbl[10] = '{32'h040, enc_i(6'h05, 0, 0, 16'h0004), 0, 1, 3, 32'h1,         32'h044, 11};
      tbl[11] = '{32'h044, enc_i(6'h04, 1, 1, 16'h0003), 1, 1, 4, 32'h8,         32'h054, 12};
      tbl[12] = '{32'h054, enc_i(6'h05, 1, 2, 16'hFFFE), 0, 1, 2, 32'h3,         32'h050, 13};
      tbl[13] = '{32'h050, enc_i(6'h04, 0, 0, 16'hFFFF), 7, 1, 5, 32'h1,         32'h050, 14};
      tbl[14] = '{32'h050, enc_r(0, 2, 9, 6'h22),        0, 1, 9, 32'hFFFF_FFFD, 32'h054, 15};
      tbl[15] = '{32'h054, enc_r(1, 2, 10, 6'h21),       0, 0, 0, 32'h0,         32'h054, 15};

      #2;
      rst8 = 1'b1;
      do_reset(1'b0, 32'h100);

      for (int i = 0; i < 16; i++) begin
         mem[tbl[i].addr[9:2]] = tbl[i].instr;
         run_instr(tbl[i].addr, tbl[i].stall, tbl[i].legal, tbl[i].dreg, tbl[i].dval,
                   tbl[i].npc, tbl[i].ncnt, $sformatf("vec%0d", i));
      end

      // Halt is sticky, frozen, ignores ready.
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk(32'(c_halt), 32'd1, "halt sticky");
         chk(32'(c_req), 32'd0, "halt req");
         chk(32'(c_ret), 32'd0, "halt retire");
         chk(c_cnt, 32'd15, "halt cnt");
         chk(c_pc, 32'h54, "halt pc");
      end
      dbg_addr = 5'd10; #1; chk(c_dbg, 32'h0, "halt no write");
      dbg_addr = 5'd9;  #1; chk(c_dbg, 32'hFFFF_FFFD, "halt regs kept");

      do_reset(1'b0, 32'h100);
      dbg_addr = 5'd1; #1; chk(c_dbg, 32'h0, "reset clears regs");

      // Reset asserted in WB drops the pending write.
      mem[32'h100 >> 2] = enc_i(6'h08, 0, 10, 16'd77);
      ready = 1'b1;
      @(posedge clk); #1; ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk(32'(c_ret), 32'd1, "midrst wb");
      rst32 = 1'b1; #1;
      chk(32'(c_ret), 32'd0, "midrst retire");
      chk(c_pc, 32'h100, "midrst pc");
      @(posedge clk); #1;
      rst32 = 1'b0;
      dbg_addr = 5'd10; #1;
      chk(c_dbg, 32'h0, "midrst no write");
      chk(c_cnt, 32'h0, "midrst cnt");

      // Opcode 0x3F halts.
      mem[32'h100 >> 2] = 32'hFC00_0000;
      run_instr(32'h100, 1, 1'b0, 5'd0, 32'h0, 32'h100, 32'd0, "op3f");
      @(posedge clk); #1;
      chk(c_pc, 32'h100, "op3f pc");
      do_reset(1'b0, 32'h100);

      // Random programs against the ISA model.
      for (int i = 0; i < 256; i++) mem[i] = rand_instr();
      model_reset(32'h100);
      for (int i = 0; i < 250; i++) begin
         logic [31:0] fa, ins;
         bit          lg;
         logic [4:0]  d;
         int          st;
         fa = m_pc;
         ins = mem[fa[9:2]];
         model_step(ins, lg, d);
         if (d == 5'd0) d = 5'($urandom);
         st = $urandom_range(0, 3);
         run_instr(fa, st, lg, d, m_regs[d], m_pc, m_cnt, $sformatf("rnd%0d", i));
      end

      // Narrow instance: 16-bit data, 8-bit PC wrap and truncation.
      rst32 = 1'b1;
      do_reset(1'b1, 32'hFC);
      mem[63] = enc_i(6'h08, 0, 5, 16'h7FFF);
      run_instr(32'hFC, 0, 1'b1, 5'd5, 32'h7FFF, 32'h00, 32'd1, "w8 addi");
      mem[0] = enc_r(5, 5, 5, 6'h20);
      run_instr(32'h00, 1, 1'b1, 5'd5, 32'hFFFE, 32'h04, 32'd2, "w8 add");
      mem[1] = enc_i(6'h04, 0, 0, 16'hFFFE);
      run_instr(32'h04, 0, 1'b1, 5'd5, 32'hFFFE, 32'h00, 32'd3, "w8 beq");
      mem[0] = enc_j(26'h3FF_FFFF);
      run_instr(32'h00, 2, 1'b1, 5'd5, 32'hFFFE, 32'hFC, 32'd4, "w8 j");
      mem[63] = enc_r(5, 0, 6, 6'h2A);
      run_instr(32'hFC, 0, 1'b1, 5'd6, 32'h1, 32'h00, 32'd5, "w8 slt");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle CPU core. Executes the same MIPS-style subset (R-type ALU ops, addi/slti, beq/bne), and adds jump. A four-state controller sequences each instruction, so instruction memory is external and reached through a req/ready handshake that may stall for any number of cycles. Register file, ALU, sign extension and PC logic are internal. A debug read port and retire counters give the bench architectural visibility.

## Interface
- DATA_W, 32: register/ALU datapath width (≥16).
- PC_W, 32: program counter and instruction address width (≥8).
- RESET_PC, 0: PC value loaded on reset (word aligned).

- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- imem_req_o  out  1  fetch request, high exactly while in FETCH.
- imem_addr_o  out  PC_W  fetch address (= PC); stable while imem_req_o high.
- imem_ready_i  in  1  instruction valid this cycle; sampled only when imem_req_o=1 and rst_i=0.
- imem_instr_i  in  32  instruction word, valid with imem_ready_i.
- retire_o  out  1  one-cycle pulse in WB of each completed instruction.
- retire_cnt_o  out  32  count of retired instructions, wraps modulo 2^32.
- halted_o  out  1  high once an illegal instruction is decoded; sticky until reset.
- pc_o  out  PC_W  current PC.
- dbg_addr_i  in  5  debug register select.
- dbg_data_o  out  DATA_W  combinational read of register dbg_addr_i (0 for $0).

## Operation
- States: FETCH → DECODE → EXEC → WB → FETCH; HALT terminal.
- FETCH: req=1, addr=PC. On req&ready latch instr into IR, go DECODE; else stay (any stall length).
- DECODE: latch A=R[rs], B=R[rt], Imm=sign-extend(instr[15:0]) to DATA_W. Illegal opcode/funct → HALT (no write, no retire).
- EXEC: latch ALUOut; for branches latch taken flag.
- WB: write result, update PC, pulse retire_o, increment retire_cnt_o, go FETCH.
- Supported encodings (op/funct hex):
  - R-type op 00, write rd: add 20, sub 22, and 24, or 25, slt 2A.
  - addi 08 and slti 0A, write rt.
  - beq 04, bne 05: no register write.
  - j 02: PC = {PC4[PC_W-1:28], instr[25:0], 2'b00}, truncated when PC_W<28.
- Everything else is illegal, including R-type with unlisted funct.
- Arithmetic: add/sub modulo 2^DATA_W, no overflow trap. slt/slti signed compare; result is 1 or 0 zero-extended.
- PC4 = PC+4 modulo 2^PC_W (wraps from all-ones region to low addresses).
- Branch target = PC4 + (Imm<<2), truncated to PC_W. beq taken iff A==B; bne taken iff A!=B; not taken → PC4.
- $0 reads 0; writes to $0 are discarded but the instruction still retires.
- HALT: req=0, retire_o=0, PC and registers frozen, halted_o=1; left only by reset.

## Timing
- Reset values while rst_i high: state FETCH, PC=RESET_PC, all registers 0, retire_cnt_o=0, retire_o=0, halted_o=0. imem_req_o=1 with imem_addr_o=RESET_PC; ready is ignored during reset.
- Reset asserted mid-instruction or in HALT aborts immediately. Pending fetch is dropped, and no partial register write occurs after assertion.
- With zero-wait memory (ready same cycle as req), each instruction takes 4 cycles FETCH, DECODE, EXEC, WB. Each stall cycle adds 1.
- Register write, PC update and retire_cnt increment take effect at the rising edge ending WB. retire_o is high during WB.
- dbg_data_o reflects the new register value from the cycle after WB.
- ready outside FETCH has no effect; instr is sampled only on the req&ready edge.

## Test plan
- Reset/fetch: RESET_PC=0x100, ready held 1 → imem_addr_o=0x100 during reset, retire pulses every 4 cycles, addresses 0x100, 0x104, 0x108.
- ALU: addi $1,$0,-5; addi $2,$0,3; slt $3,$1,$2; sub $4,$2,$1 → dbg $1=0xFFFFFFFB, $3=1, $4=8, retire_cnt_o=4.
- Branch: beq $0,$0,-1 at 0x40 → next fetch 0x40. bne $0,$0,+4 → fetch PC+4. j 0x000010 → fetch 0x40.
- Stall: ready low for 7 FETCH cycles → addr stable, no retire, instruction completes 11 cycles after FETCH entry.
- Illegal/$0: addi $0,$0,9 retires, $0 stays 0. Opcode 0x3F → halted_o=1, req=0, retire_cnt_o frozen; reset recovers with halted_o=0.
- Width params: DATA_W=16, PC_W=8, PC=0xFC, addi $5,$0,0x7FFF then add $5,$5,$5 → $5=0xFFFE, fetch after 0xFC wraps to 0x00.
